// File: rtl/matrix_addsub_seq.sv
// Sequential element-wise matrix add/subtract: captures two flattened matrices on start,
// processes LANES elements per clock and publishes the result and overflow mask atomically.
module matrix_addsub_seq #(
  parameter int unsigned ROWS  = 2,
  parameter int unsigned COLS  = 2,
  parameter int unsigned EW    = 4,
  parameter int unsigned LANES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic                      sat_en,
  input  logic [ROWS*COLS*EW-1:0]   a_in,
  input  logic [ROWS*COLS*EW-1:0]   b_in,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS*COLS*EW-1:0]   c_out,
  output logic [ROWS*COLS-1:0]      ovf_mask
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned G  = N / LANES;
  localparam int unsigned CW = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned GW = LANES * EW;
  localparam int unsigned MW = N * EW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   a_reg, b_reg, work_c, work_c_nxt;
  logic [N-1:0]    work_ovf, work_ovf_nxt;
  logic            op_reg, sat_reg;
  logic [CW-1:0]   grp;
  logic            last_grp_c;
  int unsigned     sh, lsh;
  logic [GW-1:0]   ga, gb, gc;
  logic [LANES-1:0] gov;

  // One element at EW+1 bits: returns {ovf, result}
  function automatic logic [EW:0] elem_op(input logic [EW-1:0] a, input logic [EW-1:0] b,
                                          input logic sub, input logic sat);
    logic [EW:0] s;
    logic        ovf;
    s   = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    ovf = sub ? (a < b) : s[EW];
    if (sat && ovf) s[EW-1:0] = sub ? '0 : '1;
    return {ovf, s[EW-1:0]};
  endfunction

  assign last_grp_c = (grp == CW'(G - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_grp_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current group: extract operands, compute lanes, merge back into working registers
  always_comb begin
    sh  = 32'(grp) * GW;
    lsh = 32'(grp) * LANES;
    ga  = GW'(a_reg >> sh);
    gb  = GW'(b_reg >> sh);
    gc  = '0;
    gov = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      {gov[l], gc[l*EW +: EW]} = elem_op(ga[l*EW +: EW], gb[l*EW +: EW], op_reg, sat_reg);
    end
    work_c_nxt   = (work_c & ~(MW'({GW{1'b1}}) << sh)) | (MW'(gc) << sh);
    work_ovf_nxt = (work_ovf & ~(N'({LANES{1'b1}}) << lsh)) | (N'(gov) << lsh);
  end

  // Operand capture, group stepping and atomic result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= 1'b0;
      sat_reg  <= 1'b0;
      grp      <= '0;
      work_c   <= '0;
      work_ovf <= '0;
      c_out    <= '0;
      ovf_mask <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            op_reg  <= op_sub;
            sat_reg <= sat_en;
            grp     <= '0;
          end
        end
        RUN: begin
          work_c   <= work_c_nxt;
          work_ovf <= work_ovf_nxt;
          if (last_grp_c) begin
            grp      <= '0;
            c_out    <= work_c_nxt;
            ovf_mask <= work_ovf_nxt;
          end else begin
            grp <= grp + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_addsub_seq.md
Name: matrix_addsub_seq

Overview:
Parametrised, sequential element-wise matrix adder/subtractor. It is the successor to the flat combinational matrix add block.
- Captures two ROWS x COLS matrices of EW-bit unsigned elements on a start handshake.
- Processes LANES elements per clock, in add or subtract mode, with optional saturation and per-element overflow reporting.
- Sits between operand registers and result consumers in the bit-vector/matrix datapath.

Parameters:
ROWS, 2, number of matrix rows (>=1)
COLS, 2, number of matrix columns (>=1)
EW, 4, element width in bits (>=2)
LANES, 1, elements processed per clock; must divide ROWS*COLS

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op_sub  input  1  0 = a+b, 1 = a-b; captured with start
sat_en  input  1  1 = saturate, 0 = wrap; captured with start
a_in  input  ROWS*COLS*EW  matrix A, flattened
b_in  input  ROWS*COLS*EW  matrix B, flattened
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse; result valid
c_out  output  ROWS*COLS*EW  result matrix, flattened
ovf_mask  output  ROWS*COLS  per-element overflow (add) / underflow (sub) flag

Behaviour:
- Definitions:
  - N = ROWS*COLS.
  - G = N/LANES groups.
  - Element e = r*COLS+c occupies bits [e*EW +: EW]; e=0 (row 0, col 0) is at the LSBs.
  - Group g covers elements g*LANES .. g*LANES+LANES-1.
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, c_out=0, ovf_mask=0.
  - Operand, working-result and group-counter registers are cleared.
  - No partial result is ever presented.
- States:
  - IDLE:
    - start=1 at edge k latches a_in, b_in, op_sub and sat_en into internal registers.
    - Group counter is set to 0; busy=1 after edge k; go to RUN.
  - RUN:
    - Each edge computes group g into the working-result and working-ovf registers, then g++.
    - On the edge processing g=G-1, go to DONE.
    - Input ports are ignored in RUN; changes to a_in/b_in/op_sub/sat_en do not affect the result.
    - start is ignored and is not queued.
  - DONE: one-cycle state.
    - c_out and ovf_mask are loaded atomically from the working registers at the edge entering DONE; done=1 and busy=0 during DONE.
    - Next edge: return to IDLE, done=0.
    - start in DONE is ignored; earliest new acceptance is the cycle after done.
- Latency: start accepted at edge k -> done high in the cycle after edge k+G.
- c_out and ovf_mask hold their values until the next completion or reset.
- Arithmetic per element, computed at EW+1 bits, operands unsigned:
  - Add: s = a+b; ovf = s[EW]. Wrap gives s[EW-1:0]. Saturate gives all-ones if ovf, else s[EW-1:0].
  - Sub: d = a-b; ovf = (a<b). Wrap gives d[EW-1:0] (two's complement wrap). Saturate gives 0 if ovf, else d[EW-1:0].
  - ovf_mask[e] reports the condition regardless of sat_en.
- Lanes are independent; no carry crosses element boundaries.
- G=1 (LANES=N): RUN lasts one cycle; done follows one cycle after it.

Test Plan:
1. Add wrap: ROWS=COLS=2, EW=4, LANES=1; a=16'h3210, b=16'h4444, op_sub=0, sat_en=0, start pulse at edge k -> busy high cycles k+1..k+4, done pulse after edge k+4, c_out=16'h7654, ovf_mask=4'b0000.
2. Add overflow: a=16'hF0F0, b=16'h1111. With sat_en=0 -> c_out=16'h0101, ovf_mask=4'b1010. With sat_en=1 -> c_out=16'hF1F1, ovf_mask=4'b1010.
3. Subtract underflow: a=16'h1234, b=16'h2222, op_sub=1. With sat_en=0 -> c_out=16'hF012, ovf_mask=4'b1000. With sat_en=1 -> c_out=16'h0012.
4. Busy protection: start scenario 1, then during RUN change a_in to 16'hFFFF and pulse start twice -> result still 16'h7654; exactly one done pulse; no second operation until start after done.
5. Reset mid-op: start scenario 2 (sat), drive rst_n low asynchronously after 2 RUN edges -> busy, done, c_out and ovf_mask read 0 immediately without a clock. Release rst_n and rerun scenario 1 -> correct 16'h7654 after 4 cycles.
6. Parametrised: ROWS=2, COLS=3, EW=8, LANES=2 (G=3); A elements 0x10..0x15, B elements all 0xF0, add with sat -> elements 0x10..0x0F wrap-flagged: c = 0xFF for every element, ovf_mask=6'b111111, done after 3 RUN cycles. Same run with sat_en=0 -> c elements 0x00..0x05.
